// File: rtl/dma_tx_int_coalesce.sv
// Per-channel TX completion interrupt coalescing with round-robin kick arbitration.
// Optional macro DMA_TX_INT_RETRY_LIMIT_EN: drop a channel's events after 3 consecutive MSI fails.
module dma_tx_int_coalesce #(
   parameter int unsigned CH_NUM = 8,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned TMR_W  = 16,
   parameter int unsigned VEC_W  = $clog2(CH_NUM)
) (
   input  logic              user_clk,
   input  logic              reset,
   input  logic [CH_NUM-1:0] cmpl_valid,
   input  logic [CH_NUM-1:0] cfg_ch_mask,
   input  logic [CNT_W-1:0]  cfg_thresh,
   input  logic [TMR_W-1:0]  cfg_timeout,
   input  logic              int_msi_enb,
   input  logic              int_msi_sent,
   input  logic              int_msi_fail,
   output logic              int_kick,
   output logic [VEC_W-1:0]  int_vec,
   output logic              int_busy,
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
   output logic              int_drop,
`endif
   output logic [CH_NUM-1:0] pend_status
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [TMR_W-1:0] TMR_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_KICK = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q [CH_NUM];
   logic [CNT_W-1:0]   cnt_d [CH_NUM];
   logic [TMR_W-1:0]   tmr_q [CH_NUM];
   logic [TMR_W-1:0]   tmr_d [CH_NUM];
   logic [CNT_W-1:0]   snap_q, snap_d;
   logic [VEC_W-1:0]   rr_ptr_q, rr_d;
   logic [VEC_W-1:0]   vec_d;
   logic [CH_NUM-1:0]  pend_d;
   logic [CH_NUM-1:0]  elig;
   logic [CNT_W-1:0]   thresh_eff;
   logic [CNT_W-1:0]   cnt_base;
   logic [VEC_W-1:0]   grant;
   logic               grant_vld;
   int unsigned        arb_idx;
   logic               sent_take;
   logic               drop_take;
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
   logic [1:0]         fail_cnt_q, fail_cnt_d;
`endif

   // Channel eligibility: threshold reached or coalescing timer expired
   always_comb begin
      thresh_eff = (cfg_thresh == '0) ? CNT_W'(1) : cfg_thresh;
      elig       = '0;
      for (int unsigned c = 0; c < CH_NUM; c++) begin
         elig[c] = !cfg_ch_mask[c] && (cnt_q[c] != '0) &&
                   ((cnt_q[c] >= thresh_eff) ||
                    ((cfg_timeout != '0) && (tmr_q[c] >= cfg_timeout)));
      end
   end

   // Round-robin search beginning at rr_ptr_q
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      arb_idx   = 0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         arb_idx = (32'(rr_ptr_q) + i) % CH_NUM;
         if (!grant_vld && elig[VEC_W'(arb_idx)]) begin
            grant_vld = 1'b1;
            grant     = VEC_W'(arb_idx);
         end
      end
   end

   // Next-state: FSM, snapshot, RR pointer, counters and timers
   always_comb begin
      state_d   = state_q;
      vec_d     = int_vec;
      snap_d    = snap_q;
      rr_d      = rr_ptr_q;
      sent_take = 1'b0;
      drop_take = 1'b0;
      cnt_base  = '0;
      pend_d    = '0;
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
      fail_cnt_d = fail_cnt_q;
`endif
      for (int unsigned c = 0; c < CH_NUM; c++) begin
         cnt_d[c] = cnt_q[c];
         tmr_d[c] = tmr_q[c];
      end

      case (state_q)
         ST_IDLE: begin
            if (int_msi_enb && grant_vld) begin
               state_d = ST_KICK;
               vec_d   = grant;
               snap_d  = (cmpl_valid[grant] && (cnt_q[grant] != CNT_MAX)) ?
                         cnt_q[grant] + CNT_W'(1) : cnt_q[grant];
               rr_d    = (32'(grant) == CH_NUM - 1) ? '0 : grant + VEC_W'(1);
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
               if (grant != int_vec) fail_cnt_d = '0;
`endif
            end
         end
         ST_KICK: state_d = ST_WAIT;
         ST_WAIT: begin
            if (int_msi_sent) begin
               sent_take = 1'b1;
               state_d   = ST_IDLE;
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
               fail_cnt_d = '0;
`endif
            end else if (int_msi_fail) begin
               state_d = ST_IDLE;
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
               if (fail_cnt_q == 2'd2) begin
                  drop_take  = 1'b1;
                  fail_cnt_d = '0;
               end else begin
                  fail_cnt_d = fail_cnt_q + 2'd1;
               end
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase

      for (int unsigned c = 0; c < CH_NUM; c++) begin
         cnt_base = cnt_q[c];
         if (sent_take && (int_vec == VEC_W'(c))) cnt_base = cnt_q[c] - snap_q;
         cnt_d[c] = (cmpl_valid[c] && (cnt_base != CNT_MAX)) ? cnt_base + CNT_W'(1) : cnt_base;
         if (cnt_q[c] == '0)           tmr_d[c] = '0;
         else if (tmr_q[c] != TMR_MAX) tmr_d[c] = tmr_q[c] + TMR_W'(1);
         if ((sent_take || drop_take) && (int_vec == VEC_W'(c))) tmr_d[c] = '0;
         if (drop_take && (int_vec == VEC_W'(c)))                cnt_d[c] = '0;
         pend_d[c] = (cnt_d[c] != '0);
      end
   end

   // State and registered outputs
   always_ff @(posedge user_clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         snap_q      <= '0;
         rr_ptr_q    <= '0;
         int_vec     <= '0;
         int_kick    <= 1'b0;
         int_busy    <= 1'b0;
         pend_status <= '0;
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            cnt_q[c] <= '0;
            tmr_q[c] <= '0;
         end
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
         fail_cnt_q <= '0;
         int_drop   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         rr_ptr_q    <= rr_d;
         int_vec     <= vec_d;
         int_kick    <= (state_d == ST_KICK);
         int_busy    <= (state_d != ST_IDLE);
         pend_status <= pend_d;
         for (int unsigned c = 0; c < CH_NUM; c++) begin
            cnt_q[c] <= cnt_d[c];
            tmr_q[c] <= tmr_d[c];
         end
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
         fail_cnt_q <= fail_cnt_d;
         int_drop   <= drop_take;
`endif
      end
   end

endmodule

// File: tb/tb_dma_tx_int_coalesce.sv
// Self-checking bench for dma_tx_int_coalesce: per-cycle behavioural model compare plus directed scenarios.
module tb_dma_tx_int_coalesce;

   localparam int CH   = 8;
   localparam int CMAX = 255;
   localparam int TMAX = 65535;

   logic          user_clk;
   logic          reset;
   logic [CH-1:0] cmpl_valid;
   logic [CH-1:0] cfg_ch_mask;
   logic [7:0]    cfg_thresh;
   logic [15:0]   cfg_timeout;
   logic          int_msi_enb;
   logic          int_msi_sent;
   logic          int_msi_fail;
   logic          int_kick;
   logic [2:0]    int_vec;
   logic          int_busy;
   logic [CH-1:0] pend_status;
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
   logic          int_drop;
`endif

   dma_tx_int_coalesce #(.CH_NUM(CH), .CNT_W(8), .TMR_W(16), .VEC_W(3)) dut (
      .user_clk     (user_clk),
      .reset        (reset),
      .cmpl_valid   (cmpl_valid),
      .cfg_ch_mask  (cfg_ch_mask),
      .cfg_thresh   (cfg_thresh),
      .cfg_timeout  (cfg_timeout),
      .int_msi_enb  (int_msi_enb),
      .int_msi_sent (int_msi_sent),
      .int_msi_fail (int_msi_fail),
      .int_kick     (int_kick),
      .int_vec      (int_vec),
      .int_busy     (int_busy),
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
      .int_drop     (int_drop),
`endif
      .pend_status  (pend_status)
   );

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 0;

   // Model state: per-channel event counts/timers, request phase (0 idle, 1 kick, 2 wait)
   int m_cnt [CH];
   int m_tmr [CH];
   int m_phase, m_vec, m_snap, m_rr, m_fail;
   bit m_drop;

   initial begin
      user_clk = 1'b0;
      forever #5 user_clk = ~user_clk;
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge user_clk);
      #1;
   endtask

   function automatic bit m_elig(input int c);
      int thr;
      thr = (cfg_thresh == 8'd0) ? 1 : int'(cfg_thresh);
      return !cfg_ch_mask[c] && m_cnt[c] != 0 &&
             (m_cnt[c] >= thr || (cfg_timeout != 16'd0 && m_tmr[c] >= int'(cfg_timeout)));
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int exp_pend();
      int p;
      p = 0;
      for (int c = 0; c < CH; c++) if (m_cnt[c] != 0) p |= (1 << c);
      return p;
   endfunction

   task automatic model_step();
      int  nc [CH];
      int  nt [CH];
      int  ch;
      bit  found;
      found  = 0;
      m_drop = 0;
      for (int c = 0; c < CH; c++) begin
         nc[c] = sat(m_cnt[c] + int'(cmpl_valid[c]), CMAX);
         nt[c] = (m_cnt[c] == 0) ? 0 : sat(m_tmr[c] + 1, TMAX);
      end
      if (m_phase == 0) begin
         if (int_msi_enb) begin
            for (int k = 0; k < CH; k++) begin
               ch = (m_rr + k) % CH;
               if (!found && m_elig(ch)) begin
                  found = 1;
                  if (ch != m_vec) m_fail = 0;
                  m_vec   = ch;
                  m_snap  = nc[ch];
                  m_rr    = (ch + 1) % CH;
                  m_phase = 1;
               end
            end
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else begin
         if (int_msi_sent) begin
            nc[m_vec] = sat(m_cnt[m_vec] - m_snap + int'(cmpl_valid[m_vec]), CMAX);
            nt[m_vec] = 0;
            m_fail    = 0;
            m_phase   = 0;
         end else if (int_msi_fail) begin
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
            m_fail++;
            if (m_fail == 3) begin
               nc[m_vec] = 0;
               nt[m_vec] = 0;
               m_drop    = 1;
               m_fail    = 0;
            end
`endif
            m_phase = 0;
         end
      end
      for (int c = 0; c < CH; c++) begin
         m_cnt[c] = nc[c];
         m_tmr[c] = nt[c];
      end
   endtask

   // Model advance on every active edge
   initial begin
      m_phase = 0; m_vec = 0; m_snap = 0; m_rr = 0; m_fail = 0; m_drop = 0;
      for (int c = 0; c < CH; c++) begin m_cnt[c] = 0; m_tmr[c] = 0; end
      forever begin
         @(posedge user_clk);
         if (reset) begin
            m_phase = 0; m_vec = 0; m_snap = 0; m_rr = 0; m_fail = 0; m_drop = 0;
            for (int c = 0; c < CH; c++) begin m_cnt[c] = 0; m_tmr[c] = 0; end
         end else begin
            model_step();
         end
      end
   end

   // Model compare, mid-cycle
   initial begin
      forever begin
         @(negedge user_clk);
         if (cmp_en) begin
            chk("m_kick", int'(int_kick), int'(m_phase == 1));
            chk("m_busy", int'(int_busy), int'(m_phase != 0));
            chk("m_pend", int'(pend_status), exp_pend());
            if (m_phase != 0) chk("m_vec", int'(int_vec), m_vec);
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
            chk("m_drop", int'(int_drop), int'(m_drop));
`endif
         end
      end
   end

   task automatic wait_kick(input int limit, output int n);
      n = 0;
      while (!int_kick && n < limit) begin
         step();
         n++;
      end
      chk("kick_seen", int'(int_kick), 1);
   endtask

   task automatic serve(input string name, input int exp_vec, input logic [CH-1:0] extra);
      int n;
      wait_kick(50, n);
      chk(name, int'(int_vec), exp_vec);
      step();
      int_msi_sent = 1'b1;
      cmpl_valid   = extra;
      step();
      int_msi_sent = 1'b0;
      cmpl_valid   = '0;
   endtask

   initial begin
      int n;
      reset        = 1'b1;
      cmpl_valid   = '0;
      cfg_ch_mask  = '0;
      cfg_thresh   = 8'd1;
      cfg_timeout  = 16'd0;
      int_msi_enb  = 1'b1;
      int_msi_sent = 1'b0;
      int_msi_fail = 1'b0;
      step();
      step();
      cmp_en = 1;
      chk("rst_kick", int'(int_kick), 0);
      chk("rst_vec",  int'(int_vec), 0);
      chk("rst_busy", int'(int_busy), 0);
      chk("rst_pend", int'(pend_status), 0);
      reset = 1'b0;
      step();

      // single event on ch3, thresh 1: kick two cycles later
      cmpl_valid = 8'h08;
      step();
      cmpl_valid = '0;
      chk("t1_pend", int'(pend_status[3]), 1);
      chk("t1_nokick", int'(int_kick), 0);
      step();
      chk("t1_kick", int'(int_kick), 1);
      chk("t1_vec", int'(int_vec), 3);
      step();
      chk("t1_wait_busy", int'(int_busy), 1);
      int_msi_sent = 1'b1;
      step();
      int_msi_sent = 1'b0;
      chk("t1_pend_clr", int'(pend_status), 0);
      chk("t1_idle", int'(int_busy), 0);

      // thresh 4, timeout 100, two events on ch0: timeout kick
      cfg_thresh  = 8'd4;
      cfg_timeout = 16'd100;
      cmpl_valid  = 8'h01;
      step();
      step();
      cmpl_valid = '0;
      wait_kick(200, n);
      chk("t2_latency", n + 2, 102);
      chk("t2_vec", int'(int_vec), 0);
      step();
      int_msi_sent = 1'b1;
      step();
      int_msi_sent = 1'b0;
      chk("t2_pend_clr", int'(pend_status), 0);

      // RR order: ch1, ch2, ch5 pending; new ch1 event served after ch5
      cfg_thresh  = 8'd1;
      cfg_timeout = 16'd0;
      cmpl_valid  = 8'h26;
      step();
      cmpl_valid = '0;
      serve("t3_vec_a", 1, 8'h02);
      serve("t3_vec_b", 2, 8'h00);
      serve("t3_vec_c", 5, 8'h00);
      serve("t3_vec_d", 1, 8'h00);
      chk("t3_pend_clr", int'(pend_status), 0);

      // thresh 2: ch4 snap 2, three events during request, residue 3
      cfg_thresh = 8'd2;
      cmpl_valid = 8'h10;
      step();
      step();
      cmpl_valid = '0;
      wait_kick(10, n);
      chk("t4_vec", int'(int_vec), 4);
      cmpl_valid = 8'h10;
      step();
      step();
      step();
      cmpl_valid   = '0;
      int_msi_sent = 1'b1;
      step();
      int_msi_sent = 1'b0;
      chk("t4_pend_residue", int'(pend_status[4]), 1);
      chk("t4_idle", int'(int_busy), 0);
      step();
      chk("t4_rekick", int'(int_kick), 1);
      chk("t4_rekick_vec", int'(int_vec), 4);
      step();
      int_msi_sent = 1'b1;
      step();
      int_msi_sent = 1'b0;
      chk("t4_pend_clr", int'(pend_status), 0);

      // fail on ch6
      cfg_thresh = 8'd1;
      cmpl_valid = 8'h40;
      step();
      cmpl_valid = '0;
      wait_kick(10, n);
      chk("t5_vec", int'(int_vec), 6);
`ifdef DMA_TX_INT_RETRY_LIMIT_EN
      for (int r = 0; r < 3; r++) begin
         if (r > 0) begin
            step();
            chk("t5_retry_kick", int'(int_kick), 1);
            chk("t5_retry_vec", int'(int_vec), 6);
         end
         step();
         int_msi_fail = 1'b1;
         step();
         int_msi_fail = 1'b0;
      end
      chk("t5_drop", int'(int_drop), 1);
      chk("t5_pend_drop", int'(pend_status[6]), 0);
      for (int r = 0; r < 5; r++) begin
         step();
         chk("t5_no_kick", int'(int_kick), 0);
      end
`else
      step();
      int_msi_fail = 1'b1;
      step();
      int_msi_fail = 1'b0;
      chk("t5_idle", int'(int_busy), 0);
      chk("t5_pend_kept", int'(pend_status[6]), 1);
      step();
      chk("t5_rekick", int'(int_kick), 1);
      chk("t5_rekick_vec", int'(int_vec), 6);
      step();
      int_msi_sent = 1'b1;
      step();
      int_msi_sent = 1'b0;
      chk("t5_pend_clr", int'(pend_status), 0);
`endif

      // masked ch7 counts but is never kicked until unmasked
      cfg_ch_mask = 8'h80;
      cmpl_valid  = 8'h80;
      step();
      cmpl_valid = '0;
      n = 0;
      for (int r = 0; r < 8; r++) begin
         step();
         if (int_kick) n++;
      end
      chk("t6_mask_nokick", n, 0);
      chk("t6_mask_pend", int'(pend_status[7]), 1);
      cfg_ch_mask = '0;
      step();
      chk("t6_unmask_kick", int'(int_kick), 1);
      chk("t6_unmask_vec", int'(int_vec), 7);
      step();
      int_msi_sent = 1'b1;
      step();
      int_msi_sent = 1'b0;

      // MSI disabled holds eligible ch0; enable kicks next cycle; reset in WAIT
      int_msi_enb = 1'b0;
      cmpl_valid  = 8'h01;
      step();
      cmpl_valid = '0;
      n = 0;
      for (int r = 0; r < 5; r++) begin
         step();
         if (int_kick) n++;
      end
      chk("t7_dis_nokick", n, 0);
      chk("t7_dis_pend", int'(pend_status[0]), 1);
      int_msi_enb = 1'b1;
      step();
      chk("t7_en_kick", int'(int_kick), 1);
      chk("t7_en_vec", int'(int_vec), 0);
      step();
      chk("t7_wait_busy", int'(int_busy), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t7_rst_busy", int'(int_busy), 0);
      chk("t7_rst_pend", int'(pend_status), 0);
      int_msi_sent = 1'b1;
      step();
      int_msi_sent = 1'b0;
      chk("t7_late_sent_busy", int'(int_busy), 0);
      chk("t7_late_sent_pend", int'(pend_status), 0);
      step();
      chk("t7_late_sent_kick", int'(int_kick), 0);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dma_tx_int_coalesce.md
Name: dma_tx_int_coalesce

Overview:
- Interrupt coalescing stage directly upstream of the TX MSI interrupt stage.
- Counts per-channel DMA TX completion events and raises a one-cycle int_kick with a channel vector when a channel reaches its event threshold or its timeout.
- Tracks the MSI sent/fail handshake from PCI_TRX before issuing the next kick.
- Arbitrates round-robin across channels so one busy channel cannot starve the others.

Parameters:
- CH_NUM, 8, number of DMA TX channels (2..32).
- CNT_W, 8, width of per-channel event counter and threshold.
- TMR_W, 16, width of per-channel coalescing timer and timeout.
- VEC_W, $clog2(CH_NUM), width of channel vector.

Ports:
- user_clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- cmpl_valid  input  CH_NUM  per-channel completion pulse, one event per set bit per cycle.
- cfg_ch_mask  input  CH_NUM  1 = channel masked: events still counted, never kicked.
- cfg_thresh  input  CNT_W  event threshold; 0 treated as 1.
- cfg_timeout  input  TMR_W  timeout in cycles; 0 disables the timeout.
- int_msi_enb  input  1  MSI enabled by host; gates new kicks only.
- int_msi_sent  input  1  MSI delivered pulse.
- int_msi_fail  input  1  MSI failed pulse.
- int_kick  output  1  one-cycle request to the MSI stage.
- int_vec  output  VEC_W  channel of the current request; held from KICK until return to IDLE.
- int_busy  output  1  high in KICK and WAIT states.
- pend_status  output  CH_NUM  per-channel count != 0.

Behaviour:
- Reset: all counters, timers, snapshot and RR pointer = 0; FSM = IDLE; int_kick = 0, int_vec = 0, int_busy = 0, pend_status = 0. A reset asserted mid-WAIT drops the outstanding request; late sent/fail pulses are then ignored.
- Counter: cnt[c] += cmpl_valid[c] each cycle, saturating at all-ones.
- Timer: tmr[c] clears while cnt[c] == 0, otherwise increments, saturating at all-ones.
- Eligibility: elig[c] = !cfg_ch_mask[c] && cnt[c] != 0 && (cnt[c] >= max(cfg_thresh,1) || (cfg_timeout != 0 && tmr[c] >= cfg_timeout)).
- Arbiter: round-robin starting at rr_ptr; after a grant, rr_ptr = granted channel + 1, wrapping at CH_NUM.
- FSM IDLE: if int_msi_enb && any elig → go to KICK. In the same edge, latch int_vec = grant and snap = cnt[grant] (including that cycle's event).
- FSM KICK: int_kick = 1 for exactly one cycle → WAIT.
- FSM WAIT on int_msi_sent:
  - cnt[vec] = cnt[vec] - snap + cmpl_valid[vec]; events arriving during WAIT are preserved.
  - tmr[vec] restarts from 0.
  - → IDLE.
- FSM WAIT on int_msi_fail: counts untouched, channel stays eligible → IDLE, so it is re-arbitrated next cycle.
- Sent and fail in the same cycle: sent wins.
- Sent/fail outside WAIT: ignored.
- int_msi_enb dropping during KICK/WAIT does not abort the request; it only blocks the next IDLE→KICK.
- Latency: cmpl_valid at cycle N (thresh = 1, IDLE, enabled) → cnt = 1 at N+1 → int_kick = 1 at N+2.
- Minimum spacing between kicks: 3 cycles (KICK, WAIT with sent/fail, IDLE).

Optional Feature:
- Macro: DMA_TX_INT_RETRY_LIMIT_EN.
- Defined:
  - A 2-bit consecutive-fail counter tracks the granted channel.
  - On the 3rd consecutive fail for the same channel, cnt and tmr of that channel are cleared and output int_drop (1 bit, reset 0) pulses for one cycle.
  - The fail counter clears on any sent, or on a grant to a different channel.
- Not defined: fails retry indefinitely; int_drop port absent.

Test Plan:
- thresh = 1, timeout = 0, single pulse on ch3 at N → int_kick at N+2, int_vec = 3; sent → cnt[3] = 0, pend_status = 0.
- thresh = 4, timeout = 100, 2 events on ch0 → no kick for 99 cycles after the first event; kick when tmr = 100; sent clears cnt[0] = 0.
- thresh = 1, ch1, ch2 and ch5 all pending, sent returned each time → int_vec order 1, 2, 5, then new ch1 event is served after ch5 (RR wrap).
- thresh = 2, ch4 kicked with snap = 2, 3 more ch4 events during WAIT, sent → cnt[4] = 3, a second kick follows.
- fail on ch6 → re-kick on ch6 three cycles later. With DMA_TX_INT_RETRY_LIMIT_EN: 3 fails → int_drop = 1, cnt[6] = 0, no further kick.
- int_msi_enb = 0 with ch0 eligible → no kick, pend_status[0] = 1. Enable → kick next cycle. reset asserted in WAIT → int_busy = 0 next cycle, and a later sent changes nothing.
